// File: rtl/usb_fsi_scheduler.sv
// ---------------------------------------------------------------------------
// usb_fsi_scheduler
//
// Sits between two byte-stream clients and the FTDI fast serial interface
// (FSI) engine.
//   TX: two requesters share the single FSI TX port. Arbitration is a
//       burst-limited round-robin. Each byte is tagged with the channel bit of
//       the requester that supplied it.
//   RX: bytes from the FSI engine are routed by their channel bit into one of
//       two single-byte holding registers. While either register is full,
//       o_rx_ready is held low. That stops the FTDI clock and so applies
//       backpressure.
//
// Ports
//   i_clk, i_reset_n           clock, asynchronous active-low reset
//   i_chN_tx_valid/data        requester N (N = 0,1) byte offer
//   o_chN_tx_ready             single-cycle accept pulse to requester N
//   o_tx_valid/channel/data    request to the FSI TX port
//   i_tx_busy                  FSI TX busy; a low cycle during ISSUE accepts
//   i_rx_valid/channel/data    FSI RX byte strobe with channel bit
//   o_rx_ready                 FSI RX ready; low while any holding reg is full
//   o_chN_rx_valid/data        holding register N
//   i_chN_rx_ready             consumer N pop
//   o_rx_overflow              sticky dropped-byte flag
//   i_rx_overflow_clear        clears o_rx_overflow (a new drop wins)
//
// Parameters
//   BURST_LEN (1..255)         consecutive grants one owner may take while the
//                              other channel is also requesting
//
// Configuration macro
//   USB_FSI_SCHED_CH1_PRIORITY_EN
//       When defined, ch1 wins every decision in which it is valid, and
//       BURST_LEN has no effect. When undefined, the design uses
//       burst-limited round-robin.
//
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module usb_fsi_scheduler #(
    parameter int unsigned BURST_LEN = 8
) (
    input  logic       i_clk,
    input  logic       i_reset_n,

    input  logic       i_ch0_tx_valid,
    input  logic [7:0] i_ch0_tx_data,
    output logic       o_ch0_tx_ready,
    input  logic       i_ch1_tx_valid,
    input  logic [7:0] i_ch1_tx_data,
    output logic       o_ch1_tx_ready,

    output logic       o_tx_valid,
    output logic       o_tx_channel,
    output logic [7:0] o_tx_data,
    input  logic       i_tx_busy,

    input  logic       i_rx_valid,
    input  logic       i_rx_channel,
    input  logic [7:0] i_rx_data,
    output logic       o_rx_ready,

    output logic       o_ch0_rx_valid,
    output logic [7:0] o_ch0_rx_data,
    input  logic       i_ch0_rx_ready,
    output logic       o_ch1_rx_valid,
    output logic [7:0] o_ch1_rx_data,
    input  logic       i_ch1_rx_ready,

    output logic       o_rx_overflow,
    input  logic       i_rx_overflow_clear
);

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_ISSUE = 2'd1,
        TX_WAIT  = 2'd2
    } tx_state_e;

    // ------------------------------------------------------------------
    // TX state
    // ------------------------------------------------------------------
    tx_state_e  state_q;
    logic       tx_valid_q;
    logic       tx_channel_q;
    logic [7:0] tx_data_q;
    logic       ch0_tx_ready_q;
    logic       ch1_tx_ready_q;
    logic       owner_q;
    logic [7:0] burst_cnt_q;

    logic       any_req;
    logic       win_ch;
    logic [7:0] win_data;
    logic [7:0] burst_cnt_inc;

    // ------------------------------------------------------------------
    // RX state
    // ------------------------------------------------------------------
    logic [1:0] rx_valid_q;
    logic [1:0] rx_valid_d;
    logic [7:0] rx_data_q [2];
    logic [7:0] rx_data_d [2];
    logic       rx_ready_q;
    logic       rx_ready_d;
    logic       overflow_q;
    logic       overflow_d;

    logic [1:0] rx_wr;
    logic [1:0] rx_pop;
    logic       rx_drop;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
`ifndef USB_FSI_SCHED_CH1_PRIORITY_EN
    localparam logic [7:0] BurstLenC = 8'(BURST_LEN);
`endif

    assign any_req       = i_ch0_tx_valid | i_ch1_tx_valid;
    assign win_data      = win_ch ? i_ch1_tx_data : i_ch0_tx_data;
    // The counter saturates so that a long burst with BURST_LEN = 255
    // cannot wrap back into "owner keeps the grant".
    assign burst_cnt_inc = (burst_cnt_q == 8'hFF) ? 8'hFF : burst_cnt_q + 8'd1;

    // The winner is only used in IDLE. The value doesn't matter when nobody
    // is requesting, because any_req gates the grant.
    always_comb begin
        win_ch = 1'b0;
`ifdef USB_FSI_SCHED_CH1_PRIORITY_EN
        win_ch = i_ch1_tx_valid;
`else
        if (i_ch0_tx_valid && i_ch1_tx_valid) begin
            // With both channels contending, the owner keeps the grant until
            // its burst budget is spent.
            if (burst_cnt_q < BurstLenC) begin
                win_ch = owner_q;
            end else begin
                win_ch = ~owner_q;
            end
        end else begin
            // A single requester wins outright, even if it is not the owner.
            win_ch = i_ch1_tx_valid;
        end
`endif
    end

    // ------------------------------------------------------------------
    // TX sequencing FSM
    // IDLE grants and latches the byte. ISSUE holds the request until a
    // cycle with busy low, which is the FSI accept. WAIT rides out the busy
    // time that the engine reports after the accept.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q        <= TX_IDLE;
            tx_valid_q     <= 1'b0;
            tx_channel_q   <= 1'b0;
            tx_data_q      <= 8'h00;
            ch0_tx_ready_q <= 1'b0;
            ch1_tx_ready_q <= 1'b0;
            owner_q        <= 1'b0;
            burst_cnt_q    <= 8'h00;
        end else begin
            ch0_tx_ready_q <= 1'b0;
            ch1_tx_ready_q <= 1'b0;
            case (state_q)
                TX_IDLE: begin
                    if (any_req) begin
                        tx_valid_q     <= 1'b1;
                        tx_channel_q   <= win_ch;
                        tx_data_q      <= win_data;
                        ch0_tx_ready_q <= ~win_ch;
                        ch1_tx_ready_q <= win_ch;
                        if (win_ch == owner_q) begin
                            burst_cnt_q <= burst_cnt_inc;
                        end else begin
                            owner_q     <= win_ch;
                            burst_cnt_q <= 8'd1;
                        end
                        state_q <= TX_ISSUE;
                    end
                end
                TX_ISSUE: begin
                    if (!i_tx_busy) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= TX_WAIT;
                    end
                end
                TX_WAIT: begin
                    if (!i_tx_busy) begin
                        state_q <= TX_IDLE;
                    end
                end
                default: begin
                    tx_valid_q <= 1'b0;
                    state_q    <= TX_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // RX routing
    // A write into an empty register, or into one that is being popped in
    // the same cycle, always lands. A write into a full register that is not
    // popping is dropped and raises the sticky overflow flag. o_rx_ready is
    // derived from the next-state valids. That way it falls in the same cycle
    // as the holding register fills.
    // ------------------------------------------------------------------
    assign rx_wr  = {i_rx_valid &  i_rx_channel, i_rx_valid & ~i_rx_channel};
    assign rx_pop = {rx_valid_q[1] & i_ch1_rx_ready, rx_valid_q[0] & i_ch0_rx_ready};

    always_comb begin
        rx_valid_d = rx_valid_q;
        rx_data_d  = rx_data_q;
        overflow_d = overflow_q;
        rx_drop    = 1'b0;
        for (int n = 0; n < 2; n++) begin
            if (rx_wr[n]) begin
                if (!rx_valid_q[n] || rx_pop[n]) begin
                    rx_data_d[n]  = i_rx_data;
                    rx_valid_d[n] = 1'b1;
                end else begin
                    rx_drop = 1'b1;
                end
            end else if (rx_pop[n]) begin
                rx_valid_d[n] = 1'b0;
            end
        end
        if (rx_drop) begin
            overflow_d = 1'b1;
        end else if (i_rx_overflow_clear) begin
            overflow_d = 1'b0;
        end
        rx_ready_d = ~(rx_valid_d[0] | rx_valid_d[1]);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rx_valid_q   <= 2'b00;
            rx_data_q[0] <= 8'h00;
            rx_data_q[1] <= 8'h00;
            rx_ready_q   <= 1'b1;
            overflow_q   <= 1'b0;
        end else begin
            rx_valid_q   <= rx_valid_d;
            rx_data_q[0] <= rx_data_d[0];
            rx_data_q[1] <= rx_data_d[1];
            rx_ready_q   <= rx_ready_d;
            overflow_q   <= overflow_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_tx_valid     = tx_valid_q;
    assign o_tx_channel   = tx_channel_q;
    assign o_tx_data      = tx_data_q;
    assign o_ch0_tx_ready = ch0_tx_ready_q;
    assign o_ch1_tx_ready = ch1_tx_ready_q;

    assign o_rx_ready     = rx_ready_q;
    assign o_ch0_rx_valid = rx_valid_q[0];
    assign o_ch0_rx_data  = rx_data_q[0];
    assign o_ch1_rx_valid = rx_valid_q[1];
    assign o_ch1_rx_data  = rx_data_q[1];
    assign o_rx_overflow  = overflow_q;

endmodule

// File: tb/tb_usb_fsi_scheduler.sv
// ---------------------------------------------------------------------------
// tb_usb_fsi_scheduler
//
// Self-checking bench for usb_fsi_scheduler, built with BURST_LEN = 3.
//
// The first part is a series of directed steps:
//   - reset values
//   - a single-byte transfer
//   - ISSUE hold under busy
//   - RX routing and backpressure
//   - overflow set/clear priority
//   - reset in the middle of a transfer
//
// The second part is randomized. Each requester queue is filled with random
// bytes, and the bench plays the FSI engine with random busy times. The order
// in which bytes reach the FSI port is compared against a reference order.
// That order is computed from the queue lengths alone: alternating runs of
// BURST_LEN bytes, then a drain of whichever queue is left.
//
// Honours USB_FSI_SCHED_CH1_PRIORITY_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_usb_fsi_scheduler;

    localparam int BurstLen = 3;

    logic       clk;
    logic       rstN;
    logic       ch0TxValid;
    logic [7:0] ch0TxData;
    logic       ch0TxReady;
    logic       ch1TxValid;
    logic [7:0] ch1TxData;
    logic       ch1TxReady;
    logic       txValid;
    logic       txChannel;
    logic [7:0] txData;
    logic       txBusy;
    logic       rxValid;
    logic       rxChannel;
    logic [7:0] rxData;
    logic       rxReady;
    logic       ch0RxValid;
    logic [7:0] ch0RxData;
    logic       ch0RxReady;
    logic       ch1RxValid;
    logic [7:0] ch1RxData;
    logic       ch1RxReady;
    logic       rxOverflow;
    logic       rxOverflowClear;

    int checks;
    int errors;

    // Randomized-phase state
    logic [7:0] d0[$];
    logic [7:0] d1[$];
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic       expChan[$];
    logic [7:0] expData[$];

    usb_fsi_scheduler #(
        .BURST_LEN(BurstLen)
    ) dut (
        .i_clk              (clk),
        .i_reset_n          (rstN),
        .i_ch0_tx_valid     (ch0TxValid),
        .i_ch0_tx_data      (ch0TxData),
        .o_ch0_tx_ready     (ch0TxReady),
        .i_ch1_tx_valid     (ch1TxValid),
        .i_ch1_tx_data      (ch1TxData),
        .o_ch1_tx_ready     (ch1TxReady),
        .o_tx_valid         (txValid),
        .o_tx_channel       (txChannel),
        .o_tx_data          (txData),
        .i_tx_busy          (txBusy),
        .i_rx_valid         (rxValid),
        .i_rx_channel       (rxChannel),
        .i_rx_data          (rxData),
        .o_rx_ready         (rxReady),
        .o_ch0_rx_valid     (ch0RxValid),
        .o_ch0_rx_data      (ch0RxData),
        .i_ch0_rx_ready     (ch0RxReady),
        .o_ch1_rx_valid     (ch1RxValid),
        .o_ch1_rx_data      (ch1RxData),
        .i_ch1_rx_ready     (ch1RxReady),
        .o_rx_overflow      (rxOverflow),
        .i_rx_overflow_clear(rxOverflowClear)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value with its expected value and count the result.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Drive the RX-side inputs for the coming edge.
    task automatic applyStimulus(input logic vld, input logic chn, input logic [7:0] dat,
                                 input logic pop0, input logic pop1, input logic clr);
        rxValid         = vld;
        rxChannel       = chn;
        rxData          = dat;
        ch0RxReady      = pop0;
        ch1RxReady      = pop1;
        rxOverflowClear = clr;
    endtask

    task automatic clearInputs();
        ch0TxValid = 1'b0;
        ch0TxData  = 8'h00;
        ch1TxValid = 1'b0;
        ch1TxData  = 8'h00;
        txBusy     = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic doReset();
        rstN = 1'b0;
        clearInputs();
        repeat (2) @(posedge clk);
        #4 rstN = 1'b1;
        nextCycle();
    endtask

    // Expected FSI byte order from the arbitration rules, using only queue
    // lengths. From reset, with both channels pending, ch0 gets a full run of
    // BurstLen bytes, then ch1, and so on. Once one side runs dry, the other
    // side drains. With ch1 priority, all of ch1 goes first.
    task automatic buildExpected();
        int i0;
        int i1;
        i0 = 0;
        i1 = 0;
        expChan.delete();
        expData.delete();
`ifndef USB_FSI_SCHED_CH1_PRIORITY_EN
        begin
            int own;
            int take;
            own = 0;
            while (i0 < d0.size() && i1 < d1.size()) begin
                take = 0;
                while (take < BurstLen && ((own == 0) ? (i0 < d0.size()) : (i1 < d1.size()))) begin
                    if (own == 0) begin
                        expChan.push_back(1'b0);
                        expData.push_back(d0[i0]);
                        i0++;
                    end else begin
                        expChan.push_back(1'b1);
                        expData.push_back(d1[i1]);
                        i1++;
                    end
                    take++;
                end
                own = 1 - own;
            end
        end
`endif
        while (i1 < d1.size()) begin
            expChan.push_back(1'b1);
            expData.push_back(d1[i1]);
            i1++;
        end
        while (i0 < d0.size()) begin
            expChan.push_back(1'b0);
            expData.push_back(d0[i0]);
            i0++;
        end
    endtask

    initial begin
        logic expFirstCh;
        checks = 0;
        errors = 0;

        // ---------------- Reset values ----------------
        rstN = 1'b0;
        clearInputs();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_tx_valid",   32'(txValid),    32'd0);
        checkOutput("rst_tx_channel", 32'(txChannel),  32'd0);
        checkOutput("rst_tx_data",    32'(txData),     32'd0);
        checkOutput("rst_ch0_ready",  32'(ch0TxReady), 32'd0);
        checkOutput("rst_ch1_ready",  32'(ch1TxReady), 32'd0);
        checkOutput("rst_ch0_rxv",    32'(ch0RxValid), 32'd0);
        checkOutput("rst_ch1_rxv",    32'(ch1RxValid), 32'd0);
        checkOutput("rst_ch0_rxd",    32'(ch0RxData),  32'd0);
        checkOutput("rst_ch1_rxd",    32'(ch1RxData),  32'd0);
        checkOutput("rst_rx_ready",   32'(rxReady),    32'd1);
        checkOutput("rst_overflow",   32'(rxOverflow), 32'd0);
        #3 rstN = 1'b1;
        nextCycle();

        // ---------------- Single ch0 byte 0xA5 ----------------
        $display("[TB] single ch0 byte");
        ch0TxValid = 1'b1;
        ch0TxData  = 8'hA5;
        nextCycle();
        checkOutput("single_ready0", 32'(ch0TxReady), 32'd1);
        checkOutput("single_ready1", 32'(ch1TxReady), 32'd0);
        checkOutput("single_valid",  32'(txValid),    32'd1);
        checkOutput("single_data",   32'(txData),     32'hA5);
        checkOutput("single_chan",   32'(txChannel),  32'd0);
        nextCycle();
        ch0TxValid = 1'b0;
        checkOutput("single_valid_drop", 32'(txValid),    32'd0);
        checkOutput("single_ready_drop", 32'(ch0TxReady), 32'd0);
        // The FSI busy pulse follows the accept; a new ch1 byte must wait it out.
        txBusy     = 1'b1;
        ch1TxValid = 1'b1;
        ch1TxData  = 8'hC3;
        nextCycle();
        checkOutput("wait_busy_a", 32'(txValid), 32'd0);
        nextCycle();
        checkOutput("wait_busy_b", 32'(txValid), 32'd0);
        txBusy = 1'b0;
        nextCycle();
        checkOutput("wait_to_idle", 32'(txValid), 32'd0);
        nextCycle();
        checkOutput("after_wait_valid", 32'(txValid),    32'd1);
        checkOutput("after_wait_chan",  32'(txChannel),  32'd1);
        checkOutput("after_wait_data",  32'(txData),     32'hC3);
        checkOutput("after_wait_ready", 32'(ch1TxReady), 32'd1);
        nextCycle();
        ch1TxValid = 1'b0;
        nextCycle();
        nextCycle();

        // ---------------- ISSUE hold under busy ----------------
        $display("[TB] issue hold under busy");
        txBusy     = 1'b1;
        ch1TxValid = 1'b1;
        ch1TxData  = 8'h5A;
        nextCycle();
        checkOutput("hold_grant_ready", 32'(ch1TxReady), 32'd1);
        checkOutput("hold_grant_data",  32'(txData),     32'h5A);
        for (int i = 0; i < 20; i++) begin
            nextCycle();
            if (i == 0) ch1TxData = 8'h77;
            checkOutput("hold_valid",  32'(txValid),    32'd1);
            checkOutput("hold_data",   32'(txData),     32'h5A);
            checkOutput("hold_chan",   32'(txChannel),  32'd1);
            checkOutput("hold_ready1", 32'(ch1TxReady), 32'd0);
        end
        txBusy = 1'b0;
        nextCycle();
        checkOutput("hold_release", 32'(txValid), 32'd0);
        ch1TxValid = 1'b0;
        nextCycle();
        nextCycle();

        // ---------------- RX routing / backpressure ----------------
        $display("[TB] rx routing");
        applyStimulus(1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("rx1_valid",     32'(ch1RxValid), 32'd1);
        checkOutput("rx1_data",      32'(ch1RxData),  32'h3C);
        checkOutput("rx0_untouched", 32'(ch0RxValid), 32'd0);
        checkOutput("rx_ready_low",  32'(rxReady),    32'd0);
        nextCycle();
        checkOutput("rx1_held",      32'(ch1RxValid), 32'd1);
        checkOutput("rx_ready_held", 32'(rxReady),    32'd0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("rx1_popped",    32'(ch1RxValid), 32'd0);
        checkOutput("rx_ready_back", 32'(rxReady),    32'd1);

        // ---------------- Overflow ----------------
        $display("[TB] rx overflow");
        applyStimulus(1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0);
        nextCycle();
        checkOutput("ovf_fill", 32'(ch0RxValid), 32'd1);
        applyStimulus(1'b1, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0);
        nextCycle();
        checkOutput("ovf_set",       32'(rxOverflow), 32'd1);
        checkOutput("ovf_data_kept", 32'(ch0RxData),  32'h11);
        applyStimulus(1'b1, 1'b0, 8'h33, 1'b0, 1'b0, 1'b1);
        nextCycle();
        checkOutput("ovf_set_beats_clear", 32'(rxOverflow), 32'd1);
        checkOutput("ovf_data_kept2",      32'(ch0RxData),  32'h11);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        nextCycle();
        checkOutput("ovf_cleared", 32'(rxOverflow), 32'd0);
        applyStimulus(1'b1, 1'b0, 8'h44, 1'b1, 1'b0, 1'b0);
        nextCycle();
        checkOutput("wr_pop_valid", 32'(ch0RxValid), 32'd1);
        checkOutput("wr_pop_data",  32'(ch0RxData),  32'h44);
        checkOutput("wr_pop_noovf", 32'(rxOverflow), 32'd0);
        checkOutput("wr_pop_ready", 32'(rxReady),    32'd0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("final_pop_valid", 32'(ch0RxValid), 32'd0);
        checkOutput("final_pop_ready", 32'(rxReady),    32'd1);

        // ---------------- Reset during ISSUE ----------------
        $display("[TB] reset during issue");
        ch0TxValid = 1'b1;
        ch0TxData  = 8'h99;
        txBusy     = 1'b1;
        nextCycle();
        checkOutput("pre_reset_valid", 32'(txValid), 32'd1);
        #2 rstN = 1'b0;
        #1;
        checkOutput("async_reset_valid", 32'(txValid),    32'd0);
        checkOutput("async_reset_data",  32'(txData),     32'd0);
        checkOutput("async_reset_ready", 32'(ch0TxReady), 32'd0);
        clearInputs();
        #2 rstN = 1'b1;
        ch0TxValid = 1'b1;
        ch0TxData  = 8'h12;
        ch1TxValid = 1'b1;
        ch1TxData  = 8'h34;
`ifdef USB_FSI_SCHED_CH1_PRIORITY_EN
        expFirstCh = 1'b1;
`else
        expFirstCh = 1'b0;
`endif
        nextCycle();
        checkOutput("post_reset_valid", 32'(txValid),   32'd1);
        checkOutput("post_reset_chan",  32'(txChannel), 32'(expFirstCh));
        checkOutput("post_reset_data",  32'(txData),    expFirstCh ? 32'h34 : 32'h12);

        // ---------------- Randomized arbitration ----------------
        $display("[TB] randomized arbitration");
        for (int it = 0; it < 8; it++) begin
            int n0;
            int n1;
            int got;
            int busyLeft;
            int cyc;
            logic acceptPending;
            logic r0Prev;
            logic r1Prev;

            doReset();
            n0 = (it == 0) ? 7 : int'($urandom_range(0, 10));
            n1 = (it == 0) ? 7 : int'($urandom_range(0, 10));
            d0.delete();
            d1.delete();
            for (int k = 0; k < n0; k++) d0.push_back(8'($urandom_range(0, 255)));
            for (int k = 0; k < n1; k++) d1.push_back(8'($urandom_range(0, 255)));
            q0 = d0;
            q1 = d1;
            buildExpected();

            got           = 0;
            busyLeft      = 0;
            cyc           = 0;
            acceptPending = 1'b0;
            r0Prev        = 1'b0;
            r1Prev        = 1'b0;
            ch0TxValid    = (q0.size() > 0);
            ch0TxData     = (q0.size() > 0) ? q0[0] : 8'h00;
            ch1TxValid    = (q1.size() > 0);
            ch1TxData     = (q1.size() > 0) ? q1[0] : 8'h00;

            while (got < expChan.size() && cyc < 600) begin
                nextCycle();
                cyc++;
                // Bytes whose ready pulse was seen last cycle were consumed at this edge.
                if (r0Prev && q0.size() > 0) void'(q0.pop_front());
                if (r1Prev && q1.size() > 0) void'(q1.pop_front());
                if (acceptPending) begin
                    busyLeft      = int'($urandom_range(0, 3));
                    acceptPending = 1'b0;
                end
                txBusy = (busyLeft > 0);
                if (busyLeft > 0) busyLeft--;
                ch0TxValid = (q0.size() > 0);
                ch0TxData  = (q0.size() > 0) ? q0[0] : 8'h00;
                ch1TxValid = (q1.size() > 0);
                ch1TxData  = (q1.size() > 0) ? q1[0] : 8'h00;
                r0Prev     = ch0TxReady;
                r1Prev     = ch1TxReady;
                checkOutput("ready_exclusive", 32'(ch0TxReady & ch1TxReady), 32'd0);
                if (txValid && !txBusy) begin
                    checkOutput("seq_chan", 32'(txChannel), 32'(expChan[got]));
                    checkOutput("seq_data", 32'(txData),    32'(expData[got]));
                    got++;
                    acceptPending = 1'b1;
                end
            end
            checkOutput("seq_complete", 32'(got), 32'(expChan.size()));
        end

        clearInputs();
        nextCycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/usb_fsi_scheduler.md
# usb_fsi_scheduler

Sequencing and arbitration layer between two byte-stream clients and the FTDI fast serial interface (FSI) engine. Schedules two TX requesters onto the single FSI TX port with burst-limited round-robin and tags each byte with its channel bit. Demultiplexes RX bytes by channel into per-channel holding registers. Applies RX backpressure by driving the FSI engine's RX-ready input, which stops the FTDI clock.

## Interface
- `BURST_LEN`, default 8: max consecutive bytes granted to one channel while the other is pending; legal range 1..255.
- `i_clk` in 1: system clock.
- `i_reset_n` in 1: asynchronous, active-low reset.
- `i_chN_tx_valid` in 1, N=0,1: requester N holds a byte.
- `i_chN_tx_data` in 8: requester N byte.
- `o_chN_tx_ready` out 1: single-cycle accept pulse; byte consumed on `valid && ready`.
- `o_tx_valid` out 1: to FSI TX valid.
- `o_tx_channel` out 1: to FSI TX channel.
- `o_tx_data` out 8: to FSI TX data.
- `i_tx_busy` in 1: FSI TX busy; registered, rises the cycle after an accepted request.
- `i_rx_valid` in 1: FSI RX byte strobe, one cycle.
- `i_rx_channel` in 1: FSI RX channel bit.
- `i_rx_data` in 8: FSI RX byte.
- `o_rx_ready` out 1: to FSI RX ready.
- `o_chN_rx_valid` out 1: holding register N full.
- `o_chN_rx_data` out 8: holding register N.
- `i_chN_rx_ready` in 1: consumer N pops on `valid && ready`.
- `o_rx_overflow` out 1: sticky flag, set when a byte is dropped.
- `i_rx_overflow_clear` in 1: clears `o_rx_overflow`.

## Operation
- TX FSM has three states:
  - IDLE: if any `i_chN_tx_valid`, select a winner; latch its data and channel into the `o_tx_*` registers; pulse `o_chN_tx_ready` for that channel; go to ISSUE.
  - ISSUE: hold `o_tx_valid`=1 until a cycle with `i_tx_busy`=0, which is the FSI accept. Next cycle drop `o_tx_valid`; go to WAIT.
  - WAIT: stay while `i_tx_busy`=1. When it returns to 0, go to IDLE.
- Arbitration at IDLE:
  - Only one channel valid: that channel wins.
  - Both valid: current owner keeps the grant while `burst_cnt < BURST_LEN`, otherwise the other channel wins.
  - After reset the owner is ch0.
  - `burst_cnt` (8 bit) resets to 1 when the owner changes and increments on each grant to the same owner. It saturates at 255.
  - If the owner is invalid and the other is valid, the other wins with no counter check.
- RX routing:
  - `i_rx_valid` writes `i_rx_data` into holding register `i_rx_channel` and sets its valid.
  - Pop on `o_chN_rx_valid && i_chN_rx_ready` clears the valid.
  - A write and pop on the same register in the same cycle: write wins and valid stays 1.
- `o_rx_ready` = !(`ch0_rx_valid` || `ch1_rx_valid`), registered.
- Overflow: `i_rx_valid` into a full register that is not popping the same cycle drops the byte and sets `o_rx_overflow`. Set has priority over a simultaneous clear.
- Reset mid-transfer: FSM forces IDLE and `o_tx_valid` drops to 0 immediately (async). The FSI engine handles its own reset; no byte is replayed.

## Timing
- Reset values: `o_tx_valid`=0, `o_tx_channel`=0, `o_tx_data`=0, `o_chN_tx_ready`=0, `o_chN_rx_valid`=0, `o_chN_rx_data`=0, `o_rx_ready`=1, `o_rx_overflow`=0. FSM in IDLE, owner ch0, `burst_cnt`=0.
- Requester accept to `o_tx_valid` high: 1 cycle.
- Minimum spacing between FSI requests: 3 cycles plus the FSI busy time.
- RX write to `o_chN_rx_valid`: 1 cycle.
- RX write to `o_rx_ready` low: 1 cycle. The FSI clock is gated the following edge; the FSI engine cannot complete a byte while ready is low, so overflow only flags integration faults.
- All outputs are registered.

## Configuration
- `USB_FSI_SCHED_CH1_PRIORITY_EN`:
  - Defined: ch1 wins every IDLE decision where it is valid, regardless of `burst_cnt`. ch0 is served only when ch1 is idle. `BURST_LEN` applies to nothing.
  - Undefined: burst-limited round-robin as above.

## Test plan
- Single ch0 byte 0xA5 with `i_tx_busy` low → `o_chN_tx_ready` pulse 1 cycle; `o_tx_valid`=1 with data 0xA5 and channel 0 for exactly 1 cycle; FSM returns to IDLE after the busy pulse ends.
- Both channels continuously valid, `BURST_LEN`=3 → FSI sees channel sequence 0,0,0,1,1,1,0,… With the macro defined, all bytes go to ch1 until ch1 deasserts.
- `i_tx_busy` held high 20 cycles at ISSUE entry → `o_tx_valid` held stable, data unchanged, no second accept pulse.
- RX byte 0x3C on channel 1 with consumer not ready → `o_ch1_rx_valid`=1 with data 0x3C; `o_rx_ready`=0 next cycle. Pop → `o_rx_ready`=1.
- Force `i_rx_valid` into full ch0 → byte dropped, `o_rx_overflow`=1. Clear and set in the same cycle → flag stays 1. Clear alone → 0.
- Assert `i_reset_n`=0 during ISSUE → `o_tx_valid`=0 asynchronously. After release the first grant goes to ch0.
